// File: rtl/apu_frame_sequencer_pkg.sv
// APU frame sequencer shared types and constants.
// Sequencer states plus the divider width helper.
package apu_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PRIME,
    RUN,
    PAUSE
  } state_t;

  localparam int DEFAULT_CLK_DIV = 416667;

  function automatic int div_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/apu_frame_sequencer_if.sv
// Control and strobe bundle between the song
// controller and the APU frame sequencer.
interface apu_frame_sequencer_if #(
  parameter int TEMPO_W = 8
);

  logic               i_start;
  logic               i_stop;
  logic               i_pause;
  logic [TEMPO_W-1:0] i_tempo;
  logic               i_tempo_valid;
  logic               o_tick_stb;
  logic               o_note_stb;
  logic               o_song_rst;
  logic               o_playing;
  logic               o_paused;
  logic [TEMPO_W-1:0] o_tick_count;

  modport master (
    output i_start,
    output i_stop,
    output i_pause,
    output i_tempo,
    output i_tempo_valid,
    input  o_tick_stb,
    input  o_note_stb,
    input  o_song_rst,
    input  o_playing,
    input  o_paused,
    input  o_tick_count
  );

  modport slave (
    input  i_start,
    input  i_stop,
    input  i_pause,
    input  i_tempo,
    input  i_tempo_valid,
    output o_tick_stb,
    output o_note_stb,
    output o_song_rst,
    output o_playing,
    output o_paused,
    output o_tick_count
  );

endinterface

// File: rtl/apu_frame_sequencer_strobe_divider.sv
// Cycle counter 0..N-1 with enable and clear.
// wrap is high in the enabled cycle that hits N-1.
module strobe_divider
  import apu_pkg::*;
#(
  parameter int N = 4,
  parameter int W = div_w(N)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic wrap
);

  localparam logic [W-1:0] LAST = W'(N - 1);

  logic [W-1:0] cnt;

  assign wrap = en && (cnt == LAST);

  // count while enabled, clear has priority
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= wrap ? '0 : cnt + W'(1);
    end
  end

endmodule

// File: rtl/apu_frame_sequencer.sv
// APU frame sequencer: frame ticks, note steps,
// start/stop/pause control and runtime tempo.
module apu_frame_sequencer
  import apu_pkg::*;
#(
  parameter int CLK_DIV       = DEFAULT_CLK_DIV,
  parameter int DEFAULT_TEMPO = 8,
  parameter int TEMPO_W       = 8
) (
  input  logic i_clk,
  input  logic i_rst_n,
  apu_frame_sequencer_if.slave bus
);

  localparam logic [TEMPO_W-1:0] TEMPO_RST =
    TEMPO_W'(DEFAULT_TEMPO);
  localparam logic [TEMPO_W-1:0] ONE = TEMPO_W'(1);

  state_t state_q, state_d;

  logic               div_wrap;
  logic               cnt_en;
  logic               cnt_clr;
  logic [TEMPO_W-1:0] tick_q, tick_d;
  logic [TEMPO_W-1:0] tempo_q;
  logic               tick_stb_d;
  logic               note_stb_d;
  logic               song_rst_d;

  assign cnt_en = (state_q == RUN) &&
                  !bus.i_stop && !bus.i_start;

  assign cnt_clr = bus.i_stop || bus.i_start ||
                   (state_q == IDLE) ||
                   (state_q == PRIME);

  strobe_divider #(
    .N(CLK_DIV)
  ) u_div (
    .clk  (i_clk),
    .rst_n(i_rst_n),
    .en   (cnt_en),
    .clr  (cnt_clr),
    .wrap (div_wrap)
  );

  // state register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // next state, strobes and tick-to-note counter
  always_comb begin
    state_d    = state_q;
    tick_d     = tick_q;
    tick_stb_d = 1'b0;
    note_stb_d = 1'b0;
    song_rst_d = 1'b0;
    if (bus.i_stop) begin
      state_d = IDLE;
      tick_d  = '0;
    end else if (bus.i_start) begin
      state_d    = PRIME;
      song_rst_d = 1'b1;
      tick_d     = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          tick_d = '0;
        end
        PRIME: begin
          state_d    = RUN;
          tick_stb_d = 1'b1;
          note_stb_d = 1'b1;
          tick_d     = '0;
        end
        RUN: begin
          if (bus.i_pause) state_d = PAUSE;
          if (div_wrap) begin
            tick_stb_d = 1'b1;
            if (tick_q >= tempo_q - ONE) begin
              tick_d     = '0;
              note_stb_d = 1'b1;
            end else begin
              tick_d = tick_q + ONE;
            end
          end
        end
        PAUSE: begin
          if (bus.i_pause) state_d = RUN;
        end
        default: begin
          state_d = IDLE;
          tick_d  = '0;
        end
      endcase
    end
  end

  // tick counter, tempo register and registered outputs
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      tick_q           <= '0;
      tempo_q          <= TEMPO_RST;
      bus.o_tick_stb   <= 1'b0;
      bus.o_note_stb   <= 1'b0;
      bus.o_song_rst   <= 1'b0;
      bus.o_playing    <= 1'b0;
      bus.o_paused     <= 1'b0;
      bus.o_tick_count <= '0;
    end else begin
      tick_q <= tick_d;
      if (bus.i_tempo_valid) begin
        tempo_q <= (bus.i_tempo == '0) ? ONE : bus.i_tempo;
      end
      bus.o_tick_stb   <= tick_stb_d;
      bus.o_note_stb   <= note_stb_d;
      bus.o_song_rst   <= song_rst_d;
      bus.o_playing    <= (state_d == RUN);
      bus.o_paused     <= (state_d == PAUSE);
      bus.o_tick_count <= tick_d;
    end
  end

endmodule

// File: tb/tb_apu_frame_sequencer.sv
// Scoreboard bench for apu_frame_sequencer,
// CLK_DIV=4 and DEFAULT_TEMPO=3.
module tb_apu_frame_sequencer;

  logic clk;
  logic rst_n;
  int   cyc;
  int   t0;
  int   n_chk;
  int   n_pass;

  int exp_tick[$];
  int exp_note[$];
  int exp_rst[$];

  apu_frame_sequencer_if #(.TEMPO_W(8)) bus ();

  apu_frame_sequencer #(
    .CLK_DIV      (4),
    .DEFAULT_TEMPO(3),
    .TEMPO_W      (8)
  ) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input int got,
                     input int want);
    n_chk++;
    if (got == want) n_pass++;
    else $display("FAIL %s: got %0d want %0d",
                  tag, got, want);
  endtask

  task automatic go_to(input int n);
    while (cyc - t0 < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic begin_scn();
    @(posedge clk);
    #1;
    t0 = cyc;
  endtask

  task automatic push_ticks(input int a, input int b,
                            input int step);
    for (int c = a; c <= b; c += step)
      exp_tick.push_back(t0 + c);
  endtask

  task automatic end_scn(input string name);
    chk({name, "_tick_left"}, exp_tick.size(), 0);
    chk({name, "_note_left"}, exp_note.size(), 0);
    chk({name, "_rst_left"}, exp_rst.size(), 0);
    exp_tick.delete();
    exp_note.delete();
    exp_rst.delete();
  endtask

  // pop and compare every strobe against the scoreboard
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.o_tick_stb) begin
        if (exp_tick.size() == 0) chk("tick_unexp", cyc, -1);
        else chk("tick_cyc", cyc, exp_tick.pop_front());
      end
      if (bus.o_note_stb) begin
        if (exp_note.size() == 0) chk("note_unexp", cyc, -1);
        else chk("note_cyc", cyc, exp_note.pop_front());
      end
      if (bus.o_song_rst) begin
        if (exp_rst.size() == 0) chk("rst_unexp", cyc, -1);
        else chk("rst_cyc", cyc, exp_rst.pop_front());
      end
    end
  end

  initial begin
    n_chk  = 0;
    n_pass = 0;
    t0     = 0;
    rst_n  = 1'b0;
    bus.i_start       = 1'b0;
    bus.i_stop        = 1'b0;
    bus.i_pause       = 1'b0;
    bus.i_tempo       = '0;
    bus.i_tempo_valid = 1'b0;
    #22;
    rst_n = 1'b1;
    #1;
    chk("rst_tick", int'(bus.o_tick_stb), 0);
    chk("rst_note", int'(bus.o_note_stb), 0);
    chk("rst_song", int'(bus.o_song_rst), 0);
    chk("rst_play", int'(bus.o_playing), 0);
    chk("rst_pause", int'(bus.o_paused), 0);
    chk("rst_cnt", int'(bus.o_tick_count), 0);

    // A: basic cadence, pause at 8, resume at 20
    begin_scn();
    exp_rst.push_back(t0 + 1);
    exp_tick.push_back(t0 + 2);
    exp_tick.push_back(t0 + 6);
    push_ticks(22, 38, 4);
    exp_note.push_back(t0 + 2);
    exp_note.push_back(t0 + 26);
    exp_note.push_back(t0 + 38);
    bus.i_start = 1'b1;
    go_to(1);
    bus.i_start = 1'b0;
    go_to(4);
    chk("a_play", int'(bus.o_playing), 1);
    go_to(8);
    bus.i_pause = 1'b1;
    go_to(9);
    bus.i_pause = 1'b0;
    go_to(12);
    chk("a_paused", int'(bus.o_paused), 1);
    chk("a_play_p", int'(bus.o_playing), 0);
    chk("a_cnt_p", int'(bus.o_tick_count), 1);
    go_to(20);
    bus.i_pause = 1'b1;
    go_to(21);
    bus.i_pause = 1'b0;
    go_to(24);
    chk("a_play_r", int'(bus.o_playing), 1);
    chk("a_paused_r", int'(bus.o_paused), 0);
    chk("a_cnt_r", int'(bus.o_tick_count), 2);
    go_to(40);
    bus.i_stop = 1'b1;
    go_to(41);
    bus.i_stop = 1'b0;
    chk("a_play_s", int'(bus.o_playing), 0);
    chk("a_cnt_s", int'(bus.o_tick_count), 0);
    go_to(46);
    end_scn("a");

    // B: tempo 1, tempo 0 clamp, tempo 5, tempo 2
    begin_scn();
    exp_rst.push_back(t0 + 1);
    exp_tick.push_back(t0 + 2);
    push_ticks(6, 50, 4);
    exp_note.push_back(t0 + 2);
    exp_note.push_back(t0 + 10);
    exp_note.push_back(t0 + 14);
    exp_note.push_back(t0 + 18);
    exp_note.push_back(t0 + 22);
    exp_note.push_back(t0 + 26);
    exp_note.push_back(t0 + 42);
    exp_note.push_back(t0 + 50);
    bus.i_start = 1'b1;
    go_to(1);
    bus.i_start = 1'b0;
    go_to(7);
    bus.i_tempo = 8'd1;
    bus.i_tempo_valid = 1'b1;
    go_to(8);
    bus.i_tempo_valid = 1'b0;
    go_to(16);
    chk("b_cnt_t1", int'(bus.o_tick_count), 0);
    go_to(19);
    bus.i_tempo = 8'd0;
    bus.i_tempo_valid = 1'b1;
    go_to(20);
    bus.i_tempo_valid = 1'b0;
    go_to(27);
    bus.i_tempo = 8'd5;
    bus.i_tempo_valid = 1'b1;
    go_to(28);
    bus.i_tempo_valid = 1'b0;
    go_to(39);
    bus.i_tempo = 8'd2;
    bus.i_tempo_valid = 1'b1;
    go_to(40);
    bus.i_tempo_valid = 1'b0;
    chk("b_cnt_t5", int'(bus.o_tick_count), 3);
    go_to(47);
    chk("b_cnt_t2", int'(bus.o_tick_count), 1);
    go_to(52);
    bus.i_stop = 1'b1;
    go_to(53);
    bus.i_stop = 1'b0;
    go_to(54);
    bus.i_tempo = 8'd3;
    bus.i_tempo_valid = 1'b1;
    go_to(55);
    bus.i_tempo_valid = 1'b0;
    go_to(58);
    end_scn("b");

    // C: stop+start together in RUN, pause in IDLE
    begin_scn();
    exp_rst.push_back(t0 + 1);
    exp_tick.push_back(t0 + 2);
    exp_tick.push_back(t0 + 6);
    exp_note.push_back(t0 + 2);
    bus.i_start = 1'b1;
    go_to(1);
    bus.i_start = 1'b0;
    go_to(8);
    chk("c_play", int'(bus.o_playing), 1);
    go_to(9);
    bus.i_stop  = 1'b1;
    bus.i_start = 1'b1;
    go_to(10);
    bus.i_stop  = 1'b0;
    bus.i_start = 1'b0;
    chk("c_play_s", int'(bus.o_playing), 0);
    go_to(12);
    bus.i_pause = 1'b1;
    go_to(13);
    bus.i_pause = 1'b0;
    go_to(14);
    chk("c_paused_idle", int'(bus.o_paused), 0);
    chk("c_play_idle", int'(bus.o_playing), 0);
    go_to(20);
    end_scn("c");

    // D: restart while RUN, pause during PRIME
    begin_scn();
    exp_rst.push_back(t0 + 1);
    exp_rst.push_back(t0 + 12);
    exp_tick.push_back(t0 + 2);
    exp_tick.push_back(t0 + 6);
    exp_tick.push_back(t0 + 10);
    exp_tick.push_back(t0 + 13);
    push_ticks(17, 25, 4);
    exp_note.push_back(t0 + 2);
    exp_note.push_back(t0 + 13);
    exp_note.push_back(t0 + 25);
    bus.i_start = 1'b1;
    go_to(1);
    bus.i_start = 1'b0;
    go_to(11);
    chk("d_cnt_pre", int'(bus.o_tick_count), 2);
    bus.i_start = 1'b1;
    go_to(12);
    bus.i_start = 1'b0;
    bus.i_pause = 1'b1;
    go_to(13);
    bus.i_pause = 1'b0;
    go_to(14);
    chk("d_cnt_prime", int'(bus.o_tick_count), 0);
    chk("d_paused", int'(bus.o_paused), 0);
    chk("d_play", int'(bus.o_playing), 1);
    go_to(18);
    chk("d_cnt_run", int'(bus.o_tick_count), 1);
    go_to(26);
    bus.i_stop = 1'b1;
    go_to(27);
    bus.i_stop = 1'b0;
    go_to(32);
    end_scn("d");

    // E: async reset mid-RUN, tempo back to default
    begin_scn();
    exp_rst.push_back(t0 + 1);
    exp_tick.push_back(t0 + 2);
    exp_note.push_back(t0 + 2);
    bus.i_start = 1'b1;
    go_to(1);
    bus.i_start = 1'b0;
    go_to(3);
    bus.i_tempo = 8'd5;
    bus.i_tempo_valid = 1'b1;
    go_to(4);
    bus.i_tempo_valid = 1'b0;
    go_to(6);
    chk("e_tick_pre", int'(bus.o_tick_stb), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("e_tick_async", int'(bus.o_tick_stb), 0);
    chk("e_play_async", int'(bus.o_playing), 0);
    chk("e_cnt_async", int'(bus.o_tick_count), 0);
    @(posedge clk);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("e_play_idle", int'(bus.o_playing), 0);
    end_scn("e_rst");

    begin_scn();
    exp_rst.push_back(t0 + 1);
    exp_tick.push_back(t0 + 2);
    push_ticks(6, 14, 4);
    exp_note.push_back(t0 + 2);
    exp_note.push_back(t0 + 14);
    bus.i_start = 1'b1;
    go_to(1);
    bus.i_start = 1'b0;
    go_to(11);
    chk("e_cnt", int'(bus.o_tick_count), 2);
    go_to(15);
    bus.i_stop = 1'b1;
    go_to(16);
    bus.i_stop = 1'b0;
    go_to(20);
    end_scn("e");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
